// File: rtl/writeback_unit.sv
// Writeback unit: merges ALU results and aligned load responses into one
// register-file write port and tracks outstanding loads for decode hazards.
module writeback_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_ADDR_BITS = 5,
  parameter int REG_FILE_SIZE = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_load,
  input  logic [REG_ADDR_BITS-1:0] issue_rd,
  input  logic                     alu_valid,
  input  logic [REG_ADDR_BITS-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [REG_ADDR_BITS-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0]    lsu_rdata,
  input  logic [2:0]               lsu_funct3,
  input  logic [1:0]               lsu_byte_off,
  input  logic [REG_ADDR_BITS-1:0] chk_rs1,
  input  logic [REG_ADDR_BITS-1:0] chk_rs2,
  input  logic [REG_ADDR_BITS-1:0] chk_rd,
  output logic                     stall,
  output logic                     rf_we,
  output logic [REG_ADDR_BITS-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0]    rf_wdata,
  output logic                     dbg_state
);

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_t;

  state_t                   state, next_state;
  logic [REG_FILE_SIZE-1:0] pending, pending_next;
  logic [REG_ADDR_BITS-1:0] hold_rd;
  logic [DATA_WIDTH-1:0]    hold_data;

  logic                     lsu_acc;
  logic [7:0]               ld_byte;
  logic [15:0]              ld_half;
  logic [DATA_WIDTH-1:0]    ld_aligned;

  logic                     wr_valid;
  logic [REG_ADDR_BITS-1:0] wr_rd;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     capture;
  logic                     clr_valid;
  logic [REG_ADDR_BITS-1:0] clr_rd;

  // Load response handshake: a response transfers on a rising edge where
  // lsu_valid and lsu_ready are both 1; the LSU holds its payload until then.
  assign lsu_acc   = lsu_valid & lsu_ready;
  assign dbg_state = (state == HOLD);

  assign stall = (pending[chk_rs1] && chk_rs1 != '0) ||
                 (pending[chk_rs2] && chk_rs2 != '0) ||
                 (pending[chk_rd]  && chk_rd  != '0);

  always_comb begin
    ld_byte    = lsu_rdata[7:0];
    ld_half    = lsu_byte_off[1] ? lsu_rdata[31:16] : lsu_rdata[15:0];
    ld_aligned = lsu_rdata;
    case (lsu_byte_off)
      2'd0: ld_byte = lsu_rdata[7:0];
      2'd1: ld_byte = lsu_rdata[15:8];
      2'd2: ld_byte = lsu_rdata[23:16];
      2'd3: ld_byte = lsu_rdata[31:24];
      default: ld_byte = lsu_rdata[7:0];
    endcase
    case (lsu_funct3)
      3'b000: ld_aligned = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100: ld_aligned = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b001: ld_aligned = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101: ld_aligned = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_aligned = lsu_rdata;
    endcase
  end

  // Priority: ALU, then held load, then a directly accepted load.
  always_comb begin
    next_state = state;
    wr_valid   = 1'b0;
    wr_rd      = '0;
    wr_data    = '0;
    capture    = 1'b0;
    clr_valid  = 1'b0;
    clr_rd     = '0;
    case (state)
      EMPTY: begin
        if (alu_valid) begin
          wr_valid = 1'b1;
          wr_rd    = alu_rd;
          wr_data  = alu_result;
          if (lsu_acc) begin
            capture    = 1'b1;
            next_state = HOLD;
          end
        end else if (lsu_acc) begin
          wr_valid  = 1'b1;
          wr_rd     = lsu_rd;
          wr_data   = ld_aligned;
          clr_valid = 1'b1;
          clr_rd    = lsu_rd;
        end
      end
      HOLD: begin
        wr_valid = 1'b1;
        if (alu_valid) begin
          wr_rd   = alu_rd;
          wr_data = alu_result;
        end else begin
          wr_rd      = hold_rd;
          wr_data    = hold_data;
          clr_valid  = 1'b1;
          clr_rd     = hold_rd;
          next_state = EMPTY;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // A same-edge issue to the register being retired leaves the bit set.
  always_comb begin
    pending_next = pending;
    if (clr_valid) pending_next[clr_rd] = 1'b0;
    if (issue_load && issue_rd != '0) pending_next[issue_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      pending   <= '0;
      hold_rd   <= '0;
      hold_data <= '0;
      lsu_ready <= 1'b0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      state     <= next_state;
      pending   <= pending_next;
      lsu_ready <= (next_state == EMPTY);
      if (capture) begin
        hold_rd   <= lsu_rd;
        hold_data <= ld_aligned;
      end
      rf_we    <= wr_valid && (wr_rd != '0);
      rf_waddr <= wr_rd;
      rf_wdata <= wr_data;
    end
  end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 32 and set the datapath width in bits.
REQ-002 The parameter REG_ADDR_BITS SHALL default to 5 and set the register index width.
REQ-003 The parameter REG_FILE_SIZE SHALL default to 32 and set the number of architectural registers and scoreboard bits.
REQ-004 The port clk SHALL be an input, 1 bit wide, and serve as the clock; all state SHALL update on its rising edge.
REQ-005 The port rst_n SHALL be an input, 1 bit wide, and serve as the reset, asynchronous and active-low.
REQ-006 The port issue_load SHALL be an input, 1 bit wide, and pulse for one cycle when decode issues a load.
REQ-007 The port issue_rd SHALL be an input, REG_ADDR_BITS wide, and carry the destination of the issued load.
REQ-008 The port alu_valid SHALL be an input, 1 bit wide; an ALU result is always accepted, with no ready.
REQ-009 The ports alu_rd and alu_result SHALL be inputs, REG_ADDR_BITS and DATA_WIDTH wide, carrying the ALU destination and value.
REQ-010 The port lsu_valid SHALL be an input, 1 bit wide, and lsu_ready SHALL be an output, 1 bit wide, forming the load-response handshake.
REQ-011 The ports lsu_rd, lsu_rdata, lsu_funct3 and lsu_byte_off SHALL be inputs, REG_ADDR_BITS, DATA_WIDTH, 3 and 2 bits wide, carrying the load destination, raw word, load type and address[1:0].
REQ-012 The ports chk_rs1, chk_rs2 and chk_rd SHALL be inputs, REG_ADDR_BITS wide, carrying the register indices that decode queries.
REQ-013 The port stall SHALL be an output, 1 bit wide, signalling a hazard against a pending load.
REQ-014 The ports rf_we, rf_waddr and rf_wdata SHALL be outputs, 1, REG_ADDR_BITS and DATA_WIDTH bits wide, and drive the register-file write port.

Function
REQ-015 The block SHALL keep a scoreboard pending[REG_FILE_SIZE-1:0] in which each bit marks a register with an outstanding load.
REQ-016 On issue_load with issue_rd != 0, the block SHALL set pending[issue_rd] at the next edge; issue_rd == 0 SHALL never set a bit.
REQ-017 The stall output SHALL be combinational and equal (pending[chk_rs1] & chk_rs1 != 0) | (pending[chk_rs2] & chk_rs2 != 0) | (pending[chk_rd] & chk_rd != 0).
REQ-018 The block SHALL accept a load response on any edge where lsu_valid & lsu_ready holds.
REQ-019 The block SHALL implement a 2-state FSM (EMPTY, HOLD) around a 1-entry holding register for load responses.
REQ-020 In EMPTY with lsu_ready = 1 and no alu_valid, an accepted load SHALL be written directly to the register file.
REQ-021 In EMPTY, an accepted load arriving together with alu_valid SHALL be captured into the holding register, the ALU result SHALL be written, and the FSM SHALL go to HOLD.
REQ-022 In HOLD, lsu_ready SHALL be 0; the held load SHALL be written on the first cycle without alu_valid, after which the FSM SHALL return to EMPTY.
REQ-023 In EMPTY, lsu_ready SHALL be 1.
REQ-024 The write priority SHALL be ALU first, then the held load, then a directly accepted load.
REQ-025 The outputs rf_we, rf_waddr and rf_wdata SHALL be registered, with rf_we asserted one cycle after the winning source was present at the inputs.
REQ-026 When the selected destination is 0, rf_we SHALL be 0; the source SHALL still be consumed and the FSM SHALL still advance.
REQ-027 With b = lsu_byte_off, load alignment SHALL be as follows:
- LB (000): sign-extend the byte at rdata[8b+7:8b].
- LBU (100): zero-extend that byte.
- LH (001): sign-extend the halfword at rdata[16*b[1]+15:16*b[1]], ignoring b[0].
- LHU (101): zero-extend that halfword.
- LW (010) and every other code: pass the full word and ignore b.
REQ-028 Alignment SHALL be applied before capture into the holding register, which stores the final value.
REQ-029 pending[rd] SHALL be cleared on the edge at which that load's registered write is produced.
REQ-030 If a set and a clear of the same bit coincide, the set SHALL win.
REQ-031 Decode is responsible for never issuing an ALU op or load to an rd that is pending; the block SHALL NOT detect write-after-write hazards.

Reset
REQ-032 While rst_n = 0, the block SHALL hold pending = 0, FSM = EMPTY, holding register = 0, rf_we = 0, rf_waddr = 0, rf_wdata = 0 and lsu_ready = 0.
REQ-033 lsu_ready SHALL rise to 1 on the first edge after rst_n deasserts.
REQ-034 Reset asserted mid-operation SHALL discard a held load and clear every pending bit, with no write issued.

Verification
REQ-035 Issue a load to rd=5, then query chk_rs1=5: stall=1. Then respond with LW 0xDEADBEEF: the next cycle gives rf_we=1, waddr=5, wdata=0xDEADBEEF, and pending[5] clears, so stall=0.
REQ-036 Respond with LB, rdata=0x80FF7F01, byte_off=3, rd=7: wdata=0xFFFFFF80. Repeat with LBU: 0x00000080. Repeat with LH, off=2: 0xFFFF80FF. Repeat with LHU, off=1: 0x00007F01.
REQ-037 Present alu_valid (rd=3, 0x11) and an LSU response (rd=4, LW 0x22) together: the ALU writes first and the FSM goes to HOLD with lsu_ready=0. The next cycle writes rd=4 with 0x22, then the FSM returns to EMPTY.
REQ-038 Hold alu_valid high for 3 cycles while in HOLD: the held load stays buffered, lsu_ready stays 0, and it is written in the cycle after alu_valid drops.
REQ-039 Send an ALU result and a load response both with rd=0: rf_we stays 0. Issue a load to rd=0: stall stays 0 for chk_rs1=0.
REQ-040 Assert rst_n low while in HOLD with pending[9]=1: no write occurs, pending=0, and after release a new load to rd=9 completes normally.
